// File: rtl/hp0_arbiter.sv
// hp0_arbiter: round-robin AXI4-Lite arbiter of two requesters onto the HP0 port, one transaction at a time.
// Define HP0_ARB_TIMEOUT_EN to add the response watchdog with error response and stale-response swallowing.
`ifndef HP0_ADDR_W
`define HP0_ADDR_W 32
`endif
`ifndef HP0_DATA_W
`define HP0_DATA_W 32
`endif
module hp0_arbiter #(
  parameter int AW      = `HP0_ADDR_W,
  parameter int DW      = `HP0_DATA_W,
  parameter int TIMEOUT = 1024
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic [AW-1:0]   m0_awaddr_i,
  input  logic [2:0]      m0_awprot_i,
  input  logic            m0_awvalid_i,
  output logic            m0_awready_o,
  input  logic [DW-1:0]   m0_wdata_i,
  input  logic [DW/8-1:0] m0_wstrb_i,
  input  logic            m0_wvalid_i,
  output logic            m0_wready_o,
  output logic [1:0]      m0_bresp_o,
  output logic            m0_bvalid_o,
  input  logic            m0_bready_i,
  input  logic [AW-1:0]   m0_araddr_i,
  input  logic [2:0]      m0_arprot_i,
  input  logic            m0_arvalid_i,
  output logic            m0_arready_o,
  output logic [DW-1:0]   m0_rdata_o,
  output logic [1:0]      m0_rresp_o,
  output logic            m0_rvalid_o,
  input  logic            m0_rready_i,
  input  logic [AW-1:0]   m1_awaddr_i,
  input  logic [2:0]      m1_awprot_i,
  input  logic            m1_awvalid_i,
  output logic            m1_awready_o,
  input  logic [DW-1:0]   m1_wdata_i,
  input  logic [DW/8-1:0] m1_wstrb_i,
  input  logic            m1_wvalid_i,
  output logic            m1_wready_o,
  output logic [1:0]      m1_bresp_o,
  output logic            m1_bvalid_o,
  input  logic            m1_bready_i,
  input  logic [AW-1:0]   m1_araddr_i,
  input  logic [2:0]      m1_arprot_i,
  input  logic            m1_arvalid_i,
  output logic            m1_arready_o,
  output logic [DW-1:0]   m1_rdata_o,
  output logic [1:0]      m1_rresp_o,
  output logic            m1_rvalid_o,
  input  logic            m1_rready_i,
  output logic [AW-1:0]   s_awaddr_o,
  output logic [2:0]      s_awprot_o,
  output logic            s_awvalid_o,
  input  logic            s_awready_i,
  output logic [DW-1:0]   s_wdata_o,
  output logic [DW/8-1:0] s_wstrb_o,
  output logic            s_wvalid_o,
  input  logic            s_wready_i,
  input  logic [1:0]      s_bresp_i,
  input  logic            s_bvalid_i,
  output logic            s_bready_o,
  output logic [AW-1:0]   s_araddr_o,
  output logic [2:0]      s_arprot_o,
  output logic            s_arvalid_o,
  input  logic            s_arready_i,
  input  logic [DW-1:0]   s_rdata_i,
  input  logic [1:0]      s_rresp_i,
  input  logic            s_rvalid_i,
  output logic            s_rready_o,
  output logic            busy_o,
  output logic            grant_o
);
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA} state_e;
  state_e state_q;
  logic rr_q, grant_q, busy_q, pend_q, pend_wr_q, aw_done_q, w_done_q;
  logic to_w, stale_w, req0, req1, win, fwd_aw, fwd_w, fwd_b, fwd_ar, fwd_r;
  logic sel_bready, sel_rready, b_v, r_v, aw_hs, w_hs, ar_hs, b_hs, r_hs;
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("hp0_arbiter: TIMEOUT must be at least 2");
  end
  always_comb begin
    req0 = m0_awvalid_i | m0_arvalid_i;
    req1 = m1_awvalid_i | m1_arvalid_i;
    win = (req0 && req1) ? rr_q : req1;
    fwd_aw = state_q == WR_ADDR && !aw_done_q;
    fwd_w = state_q == WR_ADDR && !w_done_q;
    fwd_b = state_q == WR_RESP && !to_w;
    fwd_ar = state_q == RD_ADDR;
    fwd_r = state_q == RD_DATA && !to_w;
    sel_bready = grant_q ? m1_bready_i : m0_bready_i;
    sel_rready = grant_q ? m1_rready_i : m0_rready_i;
    s_awaddr_o = grant_q ? m1_awaddr_i : m0_awaddr_i;
    s_awprot_o = grant_q ? m1_awprot_i : m0_awprot_i;
    s_awvalid_o = fwd_aw && (grant_q ? m1_awvalid_i : m0_awvalid_i);
    s_wdata_o = grant_q ? m1_wdata_i : m0_wdata_i;
    s_wstrb_o = grant_q ? m1_wstrb_i : m0_wstrb_i;
    s_wvalid_o = fwd_w && (grant_q ? m1_wvalid_i : m0_wvalid_i);
    s_araddr_o = grant_q ? m1_araddr_i : m0_araddr_i;
    s_arprot_o = grant_q ? m1_arprot_i : m0_arprot_i;
    s_arvalid_o = fwd_ar && (grant_q ? m1_arvalid_i : m0_arvalid_i);
    // a stale response left over from a timeout is drained while idle
    s_bready_o = (fwd_b && sel_bready) || (state_q == IDLE && stale_w);
    s_rready_o = (fwd_r && sel_rready) || (state_q == IDLE && stale_w);
    b_v = fwd_b ? s_bvalid_i : (state_q == WR_RESP && to_w);
    r_v = fwd_r ? s_rvalid_i : (state_q == RD_DATA && to_w);
    aw_hs = s_awvalid_o && s_awready_i;
    w_hs = s_wvalid_o && s_wready_i;
    ar_hs = s_arvalid_o && s_arready_i;
    b_hs = b_v && sel_bready;
    r_hs = r_v && sel_rready;
    m0_awready_o = !grant_q && fwd_aw && s_awready_i;
    m1_awready_o = grant_q && fwd_aw && s_awready_i;
    m0_wready_o = !grant_q && fwd_w && s_wready_i;
    m1_wready_o = grant_q && fwd_w && s_wready_i;
    m0_arready_o = !grant_q && fwd_ar && s_arready_i;
    m1_arready_o = grant_q && fwd_ar && s_arready_i;
    m0_bvalid_o = !grant_q && b_v;
    m1_bvalid_o = grant_q && b_v;
    m0_rvalid_o = !grant_q && r_v;
    m1_rvalid_o = grant_q && r_v;
    m0_bresp_o = to_w ? 2'b10 : s_bresp_i;
    m1_bresp_o = to_w ? 2'b10 : s_bresp_i;
    m0_rresp_o = to_w ? 2'b10 : s_rresp_i;
    m1_rresp_o = to_w ? 2'b10 : s_rresp_i;
    m0_rdata_o = to_w ? '0 : s_rdata_i;
    m1_rdata_o = to_w ? '0 : s_rdata_i;
    busy_o = busy_q;
    grant_o = grant_q;
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      rr_q <= 1'b0;
      grant_q <= 1'b0;
      busy_q <= 1'b0;
      pend_q <= 1'b0;
      pend_wr_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:
          if (pend_q) begin
            state_q <= pend_wr_q ? WR_ADDR : RD_ADDR;
            busy_q <= 1'b1;
            pend_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q <= 1'b0;
          end else if ((req0 || req1) && !stale_w) begin
            grant_q <= win;
            pend_q <= 1'b1;
            pend_wr_q <= win ? m1_awvalid_i : m0_awvalid_i;
          end
        WR_ADDR: begin
          aw_done_q <= aw_done_q || aw_hs;
          w_done_q <= w_done_q || w_hs;
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_q <= WR_RESP;
        end
        RD_ADDR: if (ar_hs) state_q <= RD_DATA;
        WR_RESP, RD_DATA:
          if (b_hs || r_hs) begin
            state_q <= IDLE;
            busy_q <= 1'b0;
            rr_q <= !grant_q;
          end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef HP0_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q;
  logic stale_q, in_resp;
  assign in_resp = state_q == WR_RESP || state_q == RD_DATA;
  assign to_w = in_resp && wd_q == WD_W'(TIMEOUT);
  assign stale_w = stale_q;
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wd_q <= '0;
      stale_q <= 1'b0;
    end else begin
      wd_q <= !in_resp ? '0 : to_w ? wd_q : wd_q + WD_W'(1);
      if (to_w && (b_hs || r_hs)) stale_q <= 1'b1;
      else if (state_q == IDLE && (s_bvalid_i || s_rvalid_i)) stale_q <= 1'b0;
    end
  end
`else
  assign to_w = 1'b0;
  assign stale_w = 1'b0;
`endif
endmodule

// File: tb/tb_hp0_arbiter.sv
// tb_hp0_arbiter: directed vector table plus hand-written corner sequences for hp0_arbiter.
module tb_hp0_arbiter;
  logic aclk, areset;
  logic [31:0] m0_awaddr_i, m0_wdata_i, m0_araddr_i, m0_rdata_o, m1_awaddr_i, m1_wdata_i, m1_araddr_i, m1_rdata_o;
  logic [2:0] m0_awprot_i, m0_arprot_i, m1_awprot_i, m1_arprot_i, s_awprot_o, s_arprot_o;
  logic [3:0] m0_wstrb_i, m1_wstrb_i, s_wstrb_o;
  logic [1:0] m0_bresp_o, m0_rresp_o, m1_bresp_o, m1_rresp_o, s_bresp_i, s_rresp_i;
  logic m0_awvalid_i, m0_awready_o, m0_wvalid_i, m0_wready_o, m0_bvalid_o, m0_bready_i;
  logic m0_arvalid_i, m0_arready_o, m0_rvalid_o, m0_rready_i;
  logic m1_awvalid_i, m1_awready_o, m1_wvalid_i, m1_wready_o, m1_bvalid_o, m1_bready_i;
  logic m1_arvalid_i, m1_arready_o, m1_rvalid_o, m1_rready_i;
  logic [31:0] s_awaddr_o, s_wdata_o, s_araddr_o, s_rdata_i;
  logic s_awvalid_o, s_awready_i, s_wvalid_o, s_wready_i, s_bvalid_i, s_bready_o;
  logic s_arvalid_o, s_arready_i, s_rvalid_i, s_rready_o, busy_o, grant_o;
  int total = 0, bad = 0, viol = 0, nb0 = 0;

  hp0_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .aclk(aclk), .areset(areset),
    .m0_awaddr_i(m0_awaddr_i), .m0_awprot_i(m0_awprot_i), .m0_awvalid_i(m0_awvalid_i), .m0_awready_o(m0_awready_o),
    .m0_wdata_i(m0_wdata_i), .m0_wstrb_i(m0_wstrb_i), .m0_wvalid_i(m0_wvalid_i), .m0_wready_o(m0_wready_o),
    .m0_bresp_o(m0_bresp_o), .m0_bvalid_o(m0_bvalid_o), .m0_bready_i(m0_bready_i),
    .m0_araddr_i(m0_araddr_i), .m0_arprot_i(m0_arprot_i), .m0_arvalid_i(m0_arvalid_i), .m0_arready_o(m0_arready_o),
    .m0_rdata_o(m0_rdata_o), .m0_rresp_o(m0_rresp_o), .m0_rvalid_o(m0_rvalid_o), .m0_rready_i(m0_rready_i),
    .m1_awaddr_i(m1_awaddr_i), .m1_awprot_i(m1_awprot_i), .m1_awvalid_i(m1_awvalid_i), .m1_awready_o(m1_awready_o),
    .m1_wdata_i(m1_wdata_i), .m1_wstrb_i(m1_wstrb_i), .m1_wvalid_i(m1_wvalid_i), .m1_wready_o(m1_wready_o),
    .m1_bresp_o(m1_bresp_o), .m1_bvalid_o(m1_bvalid_o), .m1_bready_i(m1_bready_i),
    .m1_araddr_i(m1_araddr_i), .m1_arprot_i(m1_arprot_i), .m1_arvalid_i(m1_arvalid_i), .m1_arready_o(m1_arready_o),
    .m1_rdata_o(m1_rdata_o), .m1_rresp_o(m1_rresp_o), .m1_rvalid_o(m1_rvalid_o), .m1_rready_i(m1_rready_i),
    .s_awaddr_o(s_awaddr_o), .s_awprot_o(s_awprot_o), .s_awvalid_o(s_awvalid_o), .s_awready_i(s_awready_i),
    .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o), .s_wvalid_o(s_wvalid_o), .s_wready_i(s_wready_i),
    .s_bresp_i(s_bresp_i), .s_bvalid_i(s_bvalid_i), .s_bready_o(s_bready_o),
    .s_araddr_o(s_araddr_o), .s_arprot_o(s_arprot_o), .s_arvalid_o(s_arvalid_o), .s_arready_i(s_arready_i),
    .s_rdata_i(s_rdata_i), .s_rresp_i(s_rresp_i), .s_rvalid_i(s_rvalid_i), .s_rready_o(s_rready_o),
    .busy_o(busy_o), .grant_o(grant_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // the requester that is not granted must never see a ready or a response valid
  always @(negedge aclk) begin
    if (!areset && !grant_o && (m1_awready_o || m1_wready_o || m1_arready_o || m1_bvalid_o || m1_rvalid_o)) viol++;
    if (!areset && grant_o && (m0_awready_o || m0_wready_o || m0_arready_o || m0_bvalid_o || m0_rvalid_o)) viol++;
    if (m0_bvalid_o && m0_bready_i) nb0++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] exp_addr(input logic g, input logic w);
    return 32'h100 + (g ? 32'h100 : 32'h0) + (w ? 32'h0 : 32'h4);
  endfunction

  // slave side of one transaction with immediate address readiness and one-cycle response latency
  task automatic serve(input logic eg, input logic ew);
    int c = 0;
    while (!(s_awvalid_o || s_arvalid_o) && c < 30) begin
      tick();
      c++;
    end
    if (c >= 30) begin
      total++;
      bad++;
      $display("FAIL serve_wait: no address within 30 cycles, want grant %0d", eg);
      return;
    end
    chk("grant", grant_o, eg);
    chk("kind_is_write", s_awvalid_o, ew);
    chk("arb_latency", c, 2);
    chk("busy_active", busy_o, 1);
    chk("addr", ew ? s_awaddr_o : s_araddr_o, exp_addr(eg, ew));
    chk("prot", ew ? s_awprot_o : s_arprot_o, eg ? 3'd2 : 3'd1);
    if (ew) chk("wdata", s_wdata_o, eg ? 32'h5A5A_5A5A : 32'hA5A5_A5A5);
    tick();
    if (eg) begin
      if (ew) begin m1_awvalid_i = 0; m1_wvalid_i = 0; end else m1_arvalid_i = 0;
    end else begin
      if (ew) begin m0_awvalid_i = 0; m0_wvalid_i = 0; end else m0_arvalid_i = 0;
    end
    if (ew) begin s_bvalid_i = 1; s_bresp_i = 2'b01; end
    else begin s_rvalid_i = 1; s_rdata_i = 32'hC0DE_0000 | 32'(eg); s_rresp_i = 2'b00; end
    #1;
    chk("addr_chan_off", s_awvalid_o | s_arvalid_o, 0);
    chk("resp_valid", ew ? (eg ? m1_bvalid_o : m0_bvalid_o) : (eg ? m1_rvalid_o : m0_rvalid_o), 1);
    chk("other_resp_quiet", ew ? (eg ? m0_bvalid_o : m1_bvalid_o) : (eg ? m0_rvalid_o : m1_rvalid_o), 0);
    if (ew) chk("bresp", eg ? m1_bresp_o : m0_bresp_o, 2'b01);
    else chk("rdata", eg ? m1_rdata_o : m0_rdata_o, 32'hC0DE_0000 | 32'(eg));
    tick();
    s_bvalid_i = 0;
    s_rvalid_i = 0;
    chk("busy_idle", busy_o, 0);
  endtask

  typedef struct {
    logic m0w, m0r, m1w, m1r;
    int n;
    logic [2:0] g, w;
  } vec_t;
  vec_t vt[7];

  initial begin
    int nb_start;
    vt[0] = '{0, 1, 0, 1, 2, 3'b010, 3'b000};
    vt[1] = '{0, 1, 0, 1, 2, 3'b010, 3'b000};
    vt[2] = '{0, 0, 1, 1, 2, 3'b011, 3'b001};
    vt[3] = '{1, 0, 0, 0, 1, 3'b000, 3'b001};
    vt[4] = '{0, 1, 1, 0, 2, 3'b001, 3'b001};
    vt[5] = '{1, 1, 0, 1, 3, 3'b001, 3'b010};
    vt[6] = '{1, 0, 1, 0, 2, 3'b001, 3'b011};
    areset = 1;
    {m0_awvalid_i, m0_wvalid_i, m0_arvalid_i, m1_awvalid_i, m1_wvalid_i, m1_arvalid_i} = '0;
    m0_awaddr_i = 32'h100; m0_araddr_i = 32'h104; m1_awaddr_i = 32'h200; m1_araddr_i = 32'h204;
    m0_awprot_i = 3'd1; m0_arprot_i = 3'd1; m1_awprot_i = 3'd2; m1_arprot_i = 3'd2;
    m0_wdata_i = 32'hA5A5_A5A5; m1_wdata_i = 32'h5A5A_5A5A; m0_wstrb_i = 4'hF; m1_wstrb_i = 4'hF;
    m0_bready_i = 1; m0_rready_i = 1; m1_bready_i = 1; m1_rready_i = 1;
    s_awready_i = 1; s_wready_i = 1; s_arready_i = 1;
    s_bvalid_i = 0; s_rvalid_i = 0; s_bresp_i = 0; s_rresp_i = 0; s_rdata_i = 0;
    tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_s_valids", {s_awvalid_o, s_wvalid_o, s_arvalid_o}, 0);
    chk("rst_s_readies", {s_bready_o, s_rready_o}, 0);
    chk("rst_m_readies", {m0_awready_o, m0_wready_o, m0_arready_o, m1_awready_o, m1_wready_o, m1_arready_o}, 0);
    tick();
    areset = 0;
    for (int i = 0; i < 7; i++) begin
      m0_awvalid_i = vt[i].m0w; m0_wvalid_i = vt[i].m0w; m0_arvalid_i = vt[i].m0r;
      m1_awvalid_i = vt[i].m1w; m1_wvalid_i = vt[i].m1w; m1_arvalid_i = vt[i].m1r;
      for (int j = 0; j < vt[i].n; j++) serve(vt[i].g[j], vt[i].w[j]);
    end
    // AW held off by the slave while W completes first
    s_awready_i = 0;
    m0_awvalid_i = 1; m0_wvalid_i = 1;
    tick();
    chk("stall_aw_before_grant", s_awvalid_o, 0);
    tick();
    chk("stall_aw_rises", s_awvalid_o, 1);
    chk("stall_addr", s_awaddr_o, 32'h100);
    chk("stall_wdata", s_wdata_o, 32'hA5A5_A5A5);
    chk("stall_m0_wready", m0_wready_o, 1);
    chk("stall_m0_awready", m0_awready_o, 0);
    tick();
    chk("stall_w_done", s_wvalid_o, 0);
    m0_wvalid_i = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stall_aw_held", s_awvalid_o, 1);
      chk("stall_busy", busy_o, 1);
      chk("stall_no_b", s_bready_o, 0);
    end
    s_awready_i = 1;
    #1;
    chk("stall_m0_awready_on", m0_awready_o, 1);
    tick();
    m0_awvalid_i = 0;
    chk("stall_wr_resp", {s_awvalid_o, s_bready_o, busy_o}, 3'b011);
    nb_start = nb0;
    tick();
    s_bvalid_i = 1; s_bresp_i = 2'b00;
    #1;
    chk("stall_bvalid", m0_bvalid_o, 1);
    chk("stall_bresp", m0_bresp_o, 0);
    tick();
    s_bvalid_i = 0;
    chk("stall_busy_done", busy_o, 0);
    repeat (3) tick();
    chk("stall_one_b", nb0 - nb_start, 1);
    // reset in the middle of a read
    m0_arvalid_i = 1;
    repeat (3) tick();
    m0_arvalid_i = 0;
    chk("rdata_state_busy", busy_o, 1);
    chk("rdata_state_rready", s_rready_o, 1);
    #2;
    areset = 1;
    #1;
    chk("midrst_s", {s_awvalid_o, s_wvalid_o, s_arvalid_o, s_bready_o, s_rready_o}, 0);
    chk("midrst_busy_grant", {busy_o, grant_o}, 0);
    repeat (2) @(posedge aclk);
    #1;
    areset = 0;
    m1_awvalid_i = 1; m1_wvalid_i = 1;
    serve(1, 1);
`ifdef HP0_ARB_TIMEOUT_EN
    m0_arvalid_i = 1;
    s_rdata_i = 32'hDEAD_BEEF;
    repeat (3) tick();
    m0_arvalid_i = 0;
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("wd_quiet", m0_rvalid_o, 0);
    end
    tick();
    chk("to_rvalid", m0_rvalid_o, 1);
    chk("to_rresp", m0_rresp_o, 2'b10);
    chk("to_rdata", m0_rdata_o, 0);
    m1_awvalid_i = 1; m1_wvalid_i = 1;
    tick();
    chk("stale_idle", {busy_o, s_rready_o, s_bready_o}, 3'b011);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stale_blocks_grant", {s_awvalid_o, grant_o}, 0);
    end
    s_rvalid_i = 1;
    #1;
    chk("stale_swallowed", {m0_rvalid_o, m1_rvalid_o}, 0);
    tick();
    s_rvalid_i = 0;
    serve(1, 1);
`endif
    repeat (2) tick();
    chk("nongranted_quiet", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
